// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: RV32I size/sign codes,
// sequencer states, the in-flight load descriptor and small decode helpers.
package mem_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic [1:0] offset;
        logic       split;
    } load_desc_t;

    function automatic logic is_load_code(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_store_code(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

    // size: 0 byte, 1 half, 2 word
    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && (off == 2'd3)) || ((size == 2'b10) && (off != 2'd0));
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load alignment: picks bytes out of a two-word window at the
// access offset and sign- or zero-extends them according to funct3.
module load_formatter
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] window_i,
    input  logic [1:0]         offset_i,
    input  logic [2:0]         funct3_i,
    output logic [WIDTH-1:0]   result_o
);

    logic [WIDTH-1:0] lane;

    function automatic logic [WIDTH-1:0] sext8(input logic signed [7:0] b);
        return WIDTH'(b);
    endfunction

    function automatic logic [WIDTH-1:0] sext16(input logic signed [15:0] h);
        return WIDTH'(h);
    endfunction

    assign lane = WIDTH'(window_i >> {offset_i, 3'b000});

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_LB:   result_o = sext8(lane[7:0]);
            F3_LH:   result_o = sext16(lane[15:0]);
            F3_LW:   result_o = lane;
            F3_LBU:  result_o = WIDTH'(lane[7:0]);
            F3_LHU:  result_o = WIDTH'(lane[15:0]);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-lane stores and formatted loads against a
// 1-cycle registered data memory, splitting word-crossing accesses in two.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int SIZE    = 256,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               is_load,
    input  logic               is_store,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [WIDTH-1:0]   store_data,
    output logic               stall,
    output logic               load_valid,
    output logic [WIDTH-1:0]   load_data,
    output logic [LOGSIZE-1:0] mem_word_addr,
    output logic [WIDTH-1:0]   mem_data_in,
    output logic [3:0]         mem_byte_wr_en,
    input  logic [WIDTH-1:0]   mem_data_out
);

    state_t             state_q, state_d;
    load_desc_t         desc_q, desc_d;
    logic [LOGSIZE-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]   hi_data_q, hi_data_d;
    logic [3:0]         hi_mask_q, hi_mask_d;
    logic [WIDTH-1:0]   cap_q, cap_d;

    logic [1:0]         offset;
    logic [1:0]         size;
    logic [LOGSIZE-1:0] req_word;
    logic               ld_req, st_req, st_ok, crossing;
    logic [2*WIDTH-1:0] st_window;
    logic [7:0]         st_mask;
    logic [3:0]         wr_en_raw;
    logic               stall_raw;
    logic [2*WIDTH-1:0] fmt_window;
    logic [WIDTH-1:0]   fmt_result;
    logic               unused_addr_hi;

    assign offset         = addr[1:0];
    assign size           = funct3[1:0];
    assign req_word       = addr[LOGSIZE+1:2];
    assign unused_addr_hi = ^addr[31:LOGSIZE+2];

    // Both kind bits high is treated as a no-op.
    assign ld_req   = valid_in & is_load & ~is_store;
    assign st_req   = valid_in & is_store & ~is_load;
    assign st_ok    = st_req & is_store_code(funct3);
    assign crossing = ((ld_req & is_load_code(funct3)) | st_ok) & crosses_word(size, offset);

    assign st_window = {{WIDTH{1'b0}}, store_data} << {offset, 3'b000};
    assign st_mask   = {4'b0000, size_mask(size)} << offset;

    always_comb begin
        state_d       = state_q;
        desc_d        = desc_q;
        waddr_d       = waddr_q;
        hi_data_d     = hi_data_q;
        hi_mask_d     = hi_mask_q;
        cap_d         = cap_q;
        mem_word_addr = req_word;
        mem_data_in   = st_window[WIDTH-1:0];
        wr_en_raw     = 4'b0000;
        stall_raw     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_raw = crossing;
                if (st_ok) begin
                    wr_en_raw = st_mask[3:0];
                end
                waddr_d   = (req_word == LOGSIZE'(SIZE - 1)) ? '0 : req_word + LOGSIZE'(1);
                hi_data_d = st_window[2*WIDTH-1:WIDTH];
                hi_mask_d = (st_ok & crossing) ? st_mask[7:4] : 4'b0000;
                desc_d    = '{valid: ld_req, funct3: funct3, offset: offset, split: crossing};
                if (crossing) begin
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                // Upstream holds the same request here; everything comes from the copies.
                mem_word_addr = waddr_q;
                mem_data_in   = hi_data_q;
                wr_en_raw     = hi_mask_q;
                cap_d         = mem_data_out;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            desc_q.valid <= 1'b0;
            cap_q        <= '0;
            hi_mask_q    <= 4'b0000;
        end else begin
            state_q      <= state_d;
            desc_q       <= desc_d;
            cap_q        <= cap_d;
            hi_mask_q    <= hi_mask_d;
        end
    end

    always_ff @(posedge clk) begin
        waddr_q   <= waddr_d;
        hi_data_q <= hi_data_d;
    end

    // Gating with reset keeps a reset cycle from committing a pending second-half write.
    assign stall          = stall_raw & ~reset;
    assign mem_byte_wr_en = reset ? 4'b0000 : wr_en_raw;
    assign load_valid     = desc_q.valid & (state_q == ST_IDLE) & ~reset;

    assign fmt_window = desc_q.split ? {mem_data_out, cap_q} : {{WIDTH{1'b0}}, mem_data_out};

    load_formatter #(
        .WIDTH(WIDTH)
    ) u_load_formatter (
        .window_i (fmt_window),
        .offset_i (desc_q.offset),
        .funct3_i (desc_q.funct3),
        .result_o (fmt_result)
    );

    assign load_data = load_valid ? fmt_result : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table for single-cycle accesses, hand
// sequences for split accesses, wrap and reset, load scoreboard with latency.
module tb_mem_access_unit;

    localparam int SIZE    = 256;
    localparam int LOGSIZE = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               valid_in, is_load, is_store;
    logic [2:0]         funct3;
    logic [31:0]        addr, store_data;
    logic               stall, load_valid;
    logic [31:0]        load_data;
    logic [LOGSIZE-1:0] mem_word_addr;
    logic [31:0]        mem_data_in;
    logic [3:0]         mem_byte_wr_en;
    logic [31:0]        mem_data_out;

    always #5 clk = ~clk;

    mem_access_unit #(.WIDTH(32), .SIZE(SIZE)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .is_load        (is_load),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .stall          (stall),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .mem_word_addr  (mem_word_addr),
        .mem_data_in    (mem_data_in),
        .mem_byte_wr_en (mem_byte_wr_en),
        .mem_data_out   (mem_data_out)
    );

    logic [31:0] mem [SIZE];

    always @(posedge clk) begin
        mem_data_out <= mem[mem_word_addr];
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_wr_en[b]) mem[mem_word_addr][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        vld, ld, st;
        logic [2:0]  f3;
        logic [31:0] a, sd, exp_ld;
        logic [3:0]  we;
        logic [31:0] wd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic s, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        valid_in   = v;
        is_load    = l;
        is_store   = s;
        funct3     = f;
        addr       = a;
        store_data = d;
    endtask

    task automatic push_exp(input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic check_port(input string tag, input logic st_exp, input logic [31:0] wa,
                              input logic [3:0] we, input logic [31:0] wd);
        check({tag, "_stall"}, {31'b0, stall}, {31'b0, st_exp});
        check({tag, "_waddr"}, {24'b0, mem_word_addr}, wa);
        check({tag, "_wren"}, {28'b0, mem_byte_wr_en}, {28'b0, we});
        check({tag, "_wdata"}, mem_data_in & bmask(we), wd);
    endtask

    // Load result monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (load_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_load_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("load_data", load_data, e.data);
                check("load_latency", cyc, e.due);
            end
        end else begin
            check("load_data_idle", load_data, 32'h0);
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < SIZE; i++) mem[i] = 32'h0;
        mem[0] = 32'hCAFEF00D;
        mem[1] = 32'h01020304;
        mem[4] = 32'h8899AABB;

        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000AA, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8899, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'b000, 32'h21, 32'h000000A5, 32'h0,        4'h2, 32'h0000A500});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'b001, 32'h22, 32'hFFFF1234, 32'h0,        4'hC, 32'h12340000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 32'h21, 32'h0,        32'hFFFFFFA5, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b001, 32'h22, 32'h0,        32'h00001234, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b001, 32'h21, 32'h0,        32'h000034A5, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h1234A500, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        32'h00000000, 4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0,        4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h0,        32'h0,        4'h0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0,        32'h0,        4'h0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h1234A500, 4'h0, 32'h0});

        // Reset state, with a crossing store presented while reset is held
        repeat (2) @(negedge clk);
        drive(1, 0, 1, 3'b010, 32'h13, 32'h11223344);
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_wren", {28'b0, mem_byte_wr_en}, 32'd0);
        check("rst_load_valid", {31'b0, load_valid}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);

        // Single-cycle accesses from the table
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd);
            #1;
            check_port($sformatf("vec%0d", i), 1'b0, {24'b0, vecs[i].a[9:2]}, vecs[i].we, vecs[i].wd);
            if (vecs[i].vld && vecs[i].ld && !vecs[i].st) push_exp(vecs[i].exp_ld, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);

        // Crossing SW at offset 3; garbage on the inputs during SECOND must be ignored
        @(negedge clk);
        drive(1, 0, 1, 3'b010, 32'h13, 32'h11223344);
        #1;
        check_port("sw_x_first", 1'b1, 32'd4, 4'b1000, 32'h44000000);
        @(negedge clk);
        drive(1, 1, 0, 3'b000, 32'h80, 32'h0);
        #1;
        check_port("sw_x_second", 1'b0, 32'd5, 4'b0111, 32'h00112233);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        check("sw_x_mem4", mem[4], 32'h44ADBEEF);
        check("sw_x_mem5", mem[5], 32'h00112233);

        // Crossing LW followed by back-to-back aligned loads
        @(negedge clk);
        drive(1, 1, 0, 3'b010, 32'h13, 32'h0);
        #1;
        check("lw_x_stall", {31'b0, stall}, 32'd1);
        push_exp(32'h11223344, 2);
        @(negedge clk);
        #1;
        check("lw_x_second_addr", {24'b0, mem_word_addr}, 32'd5);
        check("lw_x_second_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        drive(1, 1, 0, 3'b010, 32'h0, 32'h0);
        #1;
        push_exp(32'hCAFEF00D, 1);
        @(negedge clk);
        drive(1, 1, 0, 3'b010, 32'h4, 32'h0);
        #1;
        push_exp(32'h01020304, 1);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);

        // SH at the last byte of memory wraps to word 0
        @(negedge clk);
        drive(1, 0, 1, 3'b001, 32'h3FF, 32'h0000ABCD);
        #1;
        check_port("sh_wrap_first", 1'b1, 32'd255, 4'b1000, 32'hCD000000);
        @(negedge clk);
        #1;
        check_port("sh_wrap_second", 1'b0, 32'd0, 4'b0001, 32'h000000AB);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        check("sh_wrap_mem0", mem[0], 32'hCAFEF0AB);
        check("sh_wrap_mem255", mem[255], 32'hCD000000);
        @(negedge clk);
        drive(1, 1, 0, 3'b001, 32'h3FF, 32'h0);
        #1;
        push_exp(32'hFFFFABCD, 2);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);

        // Reset during SECOND of a crossing SW abandons the second half
        @(negedge clk);
        drive(1, 0, 1, 3'b010, 32'h17, 32'h55667788);
        #1;
        check_port("rst_x_first", 1'b1, 32'd5, 4'b1000, 32'h88000000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_x_wren", {28'b0, mem_byte_wr_en}, 32'd0);
        check("rst_x_stall", {31'b0, stall}, 32'd0);
        check("rst_x_load_valid", {31'b0, load_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 1, 0, 3'b010, 32'h18, 32'h0);
        #1;
        check_port("rst_x_resume", 1'b0, 32'd6, 4'b0000, 32'h0);
        push_exp(32'h00000000, 1);
        @(negedge clk);
        drive(1, 1, 0, 3'b010, 32'h14, 32'h0);
        #1;
        push_exp(32'h88112233, 1);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        check("rst_x_mem6", mem[6], 32'h00000000);
        check("rst_x_mem5", mem[5], 32'h88112233);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, data word width in bits (fixed 32; four 8-bit byte lanes).
REQ-002 SHALL have parameter SIZE, 256, data memory depth in words; LOGSIZE = clog2(SIZE) is derived and not overridable.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  MEM-stage request valid.
REQ-006 SHALL have port is_load / is_store  input  1 each  access kind; both high = no-op.
REQ-007 SHALL have port funct3  input  3  RV32I size/sign code.
REQ-008 SHALL have port addr  input  32  byte address; bits [LOGSIZE+1:0] used.
REQ-009 SHALL have port store_data  input  32  rs2 value, LSB-aligned.
REQ-010 SHALL have port stall  output  1  hold upstream request this cycle.
REQ-011 SHALL have port load_valid / load_data  output  1 / 32  formatted load result.
REQ-012 SHALL have ports mem_word_addr (out, LOGSIZE), mem_data_in (out, 32), mem_byte_wr_en (out, 4), mem_data_out (in, 32) to the data memory port A (1-cycle registered read, per-byte write).

Function
REQ-013 SHALL decode funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; other codes: no write, load returns 0 with load_valid.
REQ-014 SHALL classify a request as crossing when offset=addr[1:0] and size overrun word: half at offset 3, word at offset 1-3.
REQ-015 SHALL implement FSM IDLE/SECOND; IDLE->SECOND on valid crossing request; SECOND->IDLE unconditionally next cycle.
REQ-016 SHALL in IDLE drive mem_word_addr=addr[LOGSIZE+1:2]; in SECOND drive registered word address +1, wrapping modulo SIZE.
REQ-017 SHALL assert stall combinationally only in IDLE with a valid crossing request; inputs in SECOND are ignored (held copy of same request).
REQ-018 SHALL form stores as 64-bit window: data = store_data << 8*offset, mask = {1,3,15}[size] << offset; IDLE drives low 32 bits/low 4 mask bits, SECOND drives high halves.
REQ-019 SHALL drive mem_byte_wr_en=0 whenever no valid store is being issued.
REQ-020 SHALL for non-crossing loads assert load_valid exactly one cycle after issue, load_data combinationally from mem_data_out.
REQ-021 SHALL for crossing loads capture first mem_data_out in SECOND, assert load_valid two cycles after first issue, using window {mem_data_out, captured}.
REQ-022 SHALL extract bytes at window >> 8*offset, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes 32 bits.
REQ-023 SHALL track loads in a registered descriptor (valid, funct3, offset, split) so back-to-back loads each return in order, one result per cycle max.
REQ-024 SHALL drive load_data=0 when load_valid is low.

Reset
REQ-025 SHALL on reset: state IDLE, descriptor valid and load_valid 0, capture buffer 0, stall 0, mem_byte_wr_en 0.
REQ-026 SHALL on reset asserted during SECOND abandon the second access (no second-half write, no load_valid).
REQ-027 SHALL resume normal operation the first cycle after reset deasserts.

Structure
REQ-028 SHALL place funct3 load/store constants and the IDLE/SECOND state enum in shared package mem_pkg.
REQ-029 SHALL instantiate one combinational sub-module load_formatter (64-bit window, offset, funct3 -> 32-bit result).

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF -> one cycle, word 4, wr_en 4'b1111, stall 0.
REQ-031 Mem word 4=0x8899AABB; LB 0x11 -> 0xFFFFFFAA next cycle; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899.
REQ-032 SW addr 0x13 data 0x11223344 -> stall 1 one cycle; word 4 wr_en 1000 byte 0x44; word 5 wr_en 0111 bytes 0x112233.
REQ-033 Readback LW 0x13 -> load_valid two cycles after issue, data 0x11223344; back-to-back LW 0x0, LW 0x4 -> results consecutive cycles.
REQ-034 SH at last word offset 3 (SIZE=256, addr 0x3FF) -> second write to word 0 (wrap), wr_en 0001.
REQ-035 Reset asserted during SECOND of crossing SW -> second word unchanged, state IDLE, load_valid 0.
